// File: rtl/shift_xfer_ctrl.sv
// Sequencer for an N-bit right-shift full-duplex serial transfer, paced by a bit-period divider.
// Optional macro SHIFT_XFER_CTRL_B2B_EN: ACK together with START in DONE restarts without an idle cycle.
module shift_xfer_ctrl #(
    parameter int unsigned N   = 4,
    parameter int unsigned DIV = 1
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         START,
    input  logic [N-1:0] DIN,
    input  logic         SIN,
    input  logic         ACK,
    output logic         SOUT,
    output logic         SEN,
    output logic         BUSY,
    output logic         DONE,
    output logic [N-1:0] DOUT
);

    localparam int unsigned BW = $clog2(N);
    localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [BW-1:0] BitLast = BW'(N - 1);
    localparam logic [DW-1:0] DivLast = DW'(DIV - 1);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StShift = 2'd1;
    localparam logic [1:0] StDone  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [N-1:0]  q_q, q_d;
    logic [BW-1:0] bitcnt_q, bitcnt_d;
    logic [DW-1:0] divcnt_q, divcnt_d;
    logic [N-1:0]  dout_q, dout_d;
    logic [N-1:0]  shifted;

    assign shifted = {SIN, q_q[N-1:1]};
    assign SEN     = (state_q == StShift) && (divcnt_q == DivLast);

    always_comb begin
        state_d  = state_q;
        q_d      = q_q;
        bitcnt_d = bitcnt_q;
        divcnt_d = divcnt_q;
        dout_d   = dout_q;
        case (state_q)
            StIdle: begin
                if (START) begin
                    state_d  = StShift;
                    q_d      = DIN;
                    bitcnt_d = '0;
                    divcnt_d = '0;
                end
            end
            StShift: begin
                if (SEN) begin
                    q_d      = shifted;
                    bitcnt_d = bitcnt_q + BW'(1);
                    divcnt_d = '0;
                    if (bitcnt_q == BitLast) begin
                        state_d = StDone;
                        dout_d  = shifted;
                    end
                end else begin
                    divcnt_d = divcnt_q + DW'(1);
                end
            end
            StDone: begin
                if (ACK) begin
`ifdef SHIFT_XFER_CTRL_B2B_EN
                    if (START) begin
                        state_d  = StShift;
                        q_d      = DIN;
                        bitcnt_d = '0;
                        divcnt_d = '0;
                    end else begin
                        state_d = StIdle;
                    end
`else
                    state_d = StIdle;
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= StIdle;
            q_q      <= '0;
            bitcnt_q <= '0;
            divcnt_q <= '0;
            dout_q   <= '0;
        end else begin
            state_q  <= state_d;
            q_q      <= q_d;
            bitcnt_q <= bitcnt_d;
            divcnt_q <= divcnt_d;
            dout_q   <= dout_d;
        end
    end

    assign SOUT = q_q[0];
    assign BUSY = (state_q == StShift) || (state_q == StDone);
    assign DONE = (state_q == StDone);
    assign DOUT = dout_q;

endmodule

// File: tb/tb_shift_xfer_ctrl.sv
// Randomized scoreboard bench for shift_xfer_ctrl (N=4, DIV=3); honours SHIFT_XFER_CTRL_B2B_EN.
module tb_shift_xfer_ctrl;

    localparam int unsigned N   = 4;
    localparam int unsigned DIV = 3;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         START = 1'b0;
    logic [N-1:0] DIN = '0;
    logic         SIN;
    logic         ACK = 1'b0;
    logic         SOUT, SEN, BUSY, DONE;
    logic [N-1:0] DOUT;

    logic sin_drv = 1'b0;
    logic loop    = 1'b0;
    assign SIN = loop ? SOUT : sin_drv;

    shift_xfer_ctrl #(.N(N), .DIV(DIV)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .START (START),
        .DIN   (DIN),
        .SIN   (SIN),
        .ACK   (ACK),
        .SOUT  (SOUT),
        .SEN   (SEN),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .DOUT  (DOUT)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Words expected on SOUT (bit k during bit period k) and on DOUT at completion.
    logic [N-1:0] sout_q[$];
    logic [N-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: follows each transfer from the outside and compares against the spec rules.
    bit           mon_active = 0;
    bit           prev_shift = 0;
    bit           prev_done  = 0;
    int           mon_idx = 0;
    int           mon_cyc = 0;
    logic [N-1:0] mon_word = '0;
    logic [N-1:0] hold_dout = '0;
    logic [N-1:0] exp_word;

    always @(negedge CLK) begin
        if (RST) begin
            mon_active = 0;
            prev_shift = 0;
            prev_done  = 0;
        end else begin
            if (BUSY && !DONE && !prev_shift) begin
                if (sout_q.size() == 0) begin
                    check("unexpected_start", 1, 0);
                end else begin
                    mon_word   = sout_q.pop_front();
                    mon_active = 1;
                    mon_idx    = 0;
                    mon_cyc    = 0;
                end
            end
            if (BUSY && !DONE && mon_active) begin
                if (mon_idx < N) check("sout_bit", SOUT, mon_word[mon_idx]);
                check("sen_pace", SEN, (mon_cyc == DIV - 1) ? 1 : 0);
                mon_cyc++;
                if (mon_cyc == DIV) begin
                    mon_cyc = 0;
                    mon_idx++;
                end
            end else begin
                check("sen_idle", SEN, 0);
            end
            if (DONE) check("busy_in_done", BUSY, 1);
            if (DONE && !prev_done) begin
                check("done_after_n_bits", mon_idx, mon_active ? N : -1);
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    exp_word = exp_q.pop_front();
                    check("dout_word", DOUT, exp_word);
                end
                hold_dout  = DOUT;
                mon_active = 0;
            end else if (DONE) begin
                check("dout_hold", DOUT, hold_dout);
            end
            prev_shift = BUSY && !DONE;
            prev_done  = DONE;
        end
    end

    // Request a transfer from IDLE; returns just after the accepting edge.
    task automatic accept(input logic [N-1:0] din, input logic [N-1:0] sin_word,
                          input bit lb, input bit push_exp);
        @(negedge CLK);
        START = 1'b1;
        DIN   = din;
        loop  = lb;
        sout_q.push_back(din);
        if (push_exp) exp_q.push_back(lb ? din : sin_word);
        @(posedge CLK);
    endtask

    // Drive SIN per bit period for ncyc cycles, optionally with ignored START/ACK pulses.
    task automatic shift_cycles(input logic [N-1:0] sin_word, input bit noise, input int ncyc);
        for (int j = 0; j < ncyc; j++) begin
            @(negedge CLK);
            START   = noise ? 1'($urandom) : 1'b0;
            ACK     = noise ? 1'($urandom) : 1'b0;
            DIN     = N'($urandom);
            sin_drv = sin_word[j / DIV];
        end
    endtask

    task automatic wait_done();
        @(negedge CLK);
        START = 1'b0;
        ACK   = 1'b0;
        check("done_latency", DONE, 1);
        repeat ($urandom_range(0, 5)) @(negedge CLK);
    endtask

    task automatic ack_done();
        ACK = 1'b1;
        @(negedge CLK);
        ACK = 1'b0;
        check("idle_after_ack_busy", BUSY, 0);
        check("idle_after_ack_done", DONE, 0);
    endtask

    task automatic full_xfer(input logic [N-1:0] din, input logic [N-1:0] sin_word,
                             input bit lb, input bit noise);
        accept(din, sin_word, lb, 1);
        shift_cycles(sin_word, noise, N * DIV);
        wait_done();
        ack_done();
        repeat ($urandom_range(0, 2)) @(negedge CLK);
    endtask

    logic [N-1:0] d, s;

    initial begin
        // Reset with random inputs.
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            START = 1'($urandom); ACK = 1'($urandom); DIN = N'($urandom); sin_drv = 1'($urandom);
            #1;
            check("rst_sout", SOUT, 0);
            check("rst_sen", SEN, 0);
            check("rst_busy", BUSY, 0);
            check("rst_done", DONE, 0);
            check("rst_dout", DOUT, 0);
        end
        @(negedge CLK);
        START = 1'b0;
        #2 RST = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            ACK = 1'($urandom); DIN = N'($urandom);
            check("idle_hold_busy", BUSY, 0);
        end
        ACK = 1'b0;

        // Directed: basic, loopbacks, protocol noise.
        full_xfer(4'b1010, 4'b1001, 0, 0);
        full_xfer(4'b0110, 4'b0000, 1, 0);
        full_xfer(4'b1010, 4'b0000, 1, 0);
        full_xfer(4'b1100, 4'b0101, 0, 1);

        // Abort mid-transfer after two bits, then a clean transfer.
        accept(4'b1011, 4'b0000, 1, 0);
        shift_cycles(4'b0000, 0, 2 * DIV);
        #1 RST = 1'b1;
        #1;
        check("abort_sout", SOUT, 0);
        check("abort_sen", SEN, 0);
        check("abort_busy", BUSY, 0);
        check("abort_done", DONE, 0);
        check("abort_dout", DOUT, 0);
        @(negedge CLK);
        #2 RST = 1'b0;
        full_xfer(4'b0011, 4'b1110, 0, 0);

        // START together with ACK in DONE.
        accept(4'b0101, 4'b0000, 1, 1);
        shift_cycles(4'b0000, 0, N * DIV);
        wait_done();
        START = 1'b1;
        ACK   = 1'b1;
        DIN   = 4'b1001;
`ifdef SHIFT_XFER_CTRL_B2B_EN
        loop = 1'b1;
        sout_q.push_back(4'b1001);
        exp_q.push_back(4'b1001);
        @(posedge CLK);
        #1;
        check("b2b_busy", BUSY, 1);
        check("b2b_done", DONE, 0);
        check("b2b_sout", SOUT, 1);
        shift_cycles(4'b0000, 0, N * DIV);
        wait_done();
        ack_done();
`else
        @(posedge CLK);
        #1;
        check("no_b2b_busy", BUSY, 0);
        check("no_b2b_done", DONE, 0);
        @(negedge CLK);
        START = 1'b0;
        ACK   = 1'b0;
`endif

        // Randomized transfers.
        for (int i = 0; i < 20; i++) begin
            d = N'($urandom);
            s = N'($urandom);
            full_xfer(d, s, 1'($urandom), 1'($urandom));
        end

        repeat (3) @(negedge CLK);
        check("exp_queue_drained", exp_q.size(), 0);
        check("sout_queue_drained", sout_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
